instr_exec_sequencer: RTL and testbench

INSTR_EXEC_SEQUENCER -- requirements
Module: instr_exec_sequencer

---
 rtl/instr_register_pkg.sv | 35 +++
 rtl/seq_divider.sv | 75 +++++++
 rtl/instr_exec_sequencer.sv | 150 +++++++++++++++
 tb/tb_instr_exec_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types and constants for the instruction execution sequencer and its divider.
package instr_register_pkg;

  localparam int unsigned DIV_CYCLES = 32;

  typedef logic        [4:0]  address_t;
  typedef logic        [3:0]  opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;

  localparam opcode_t OP_ZERO  = 4'd0;
  localparam opcode_t OP_PASSA = 4'd1;
  localparam opcode_t OP_PASSB = 4'd2;
  localparam opcode_t OP_ADD   = 4'd3;
  localparam opcode_t OP_SUB   = 4'd4;
  localparam opcode_t OP_MULT  = 4'd5;
  localparam opcode_t OP_DIV   = 4'd6;
  localparam opcode_t OP_MOD   = 4'd7;

  typedef struct packed {
    opcode_t  opcode;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    DIVWAIT,
    OUTPUT,
    DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Signed restoring divider: 32 iterations, quotient truncates toward zero,
// remainder takes the sign of the dividend.
module seq_divider
  import instr_register_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  operand_t dividend,
  input  operand_t divisor,
  output result_t  quotient,
  output result_t  remainder,
  output logic     div_done
);

  localparam int unsigned ITER_W = $clog2(DIV_CYCLES);

  logic [31:0]       quo;
  logic [31:0]       rem;
  logic [31:0]       dvs;
  logic [ITER_W-1:0] iter;
  logic              running;
  logic              q_neg;
  logic              r_neg;

  function automatic logic [31:0] magnitude(input operand_t v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // One restoring step on {rem, quo}; rem < divisor keeps the shifted value within 32 bits.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] trial;
    trial = {r, q[31]} - {1'b0, d};
    if (trial[32]) return {r[30:0], q[31], q[30:0], 1'b0};
    else           return {trial[31:0], q[30:0], 1'b1};
  endfunction

  // The first iteration happens on the start edge so the last lands DIV_CYCLES-1 edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      iter     <= '0;
      running  <= 1'b0;
      div_done <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (start) begin
        {rem, quo} <= div_step(32'd0, magnitude(dividend), magnitude(divisor));
        dvs        <= magnitude(divisor);
        iter       <= ITER_W'(1);
        running    <= 1'b1;
        q_neg      <= dividend[31] ^ divisor[31];
        r_neg      <= dividend[31];
      end else if (running) begin
        {rem, quo} <= div_step(rem, quo, dvs);
        iter       <= iter + 1'b1;
        if (iter == ITER_W'(DIV_CYCLES - 1)) begin
          running  <= 1'b0;
          div_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    quotient  = q_neg ? -$signed({32'd0, quo}) : $signed({32'd0, quo});
    remainder = r_neg ? -$signed({32'd0, rem}) : $signed({32'd0, rem});
  end

endmodule

// File: rtl/instr_exec_sequencer.sv
// Fetches a batch of instructions from a register file, executes each one and
// hands the results out over a valid/ready interface.
module instr_exec_sequencer
  import instr_register_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  address_t     start_addr,
  input  logic [5:0]   count,
  output logic         busy,
  output logic         done,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output address_t     res_addr,
  output opcode_t      res_opcode,
  output result_t      res_value,
  output logic         res_err
);

  state_t       state;
  address_t     addr;
  logic [5:0]   remaining;
  instruction_t instr;

  result_t      a64;
  result_t      b64;
  result_t      exec_value;
  logic         exec_err;
  logic         exec_div;
  logic         div_start;
  logic         div_done;
  result_t      quotient;
  result_t      remainder;

  always_comb begin
    a64        = {{32{instr.op_a[31]}}, instr.op_a};
    b64        = {{32{instr.op_b[31]}}, instr.op_b};
    exec_value = '0;
    exec_err   = 1'b0;
    exec_div   = 1'b0;
    case (instr.opcode)
      OP_ZERO:  exec_value = '0;
      OP_PASSA: exec_value = a64;
      OP_PASSB: exec_value = b64;
      OP_ADD:   exec_value = a64 + b64;
      OP_SUB:   exec_value = a64 - b64;
      OP_MULT:  exec_value = a64 * b64;
      OP_DIV, OP_MOD: begin
        if (instr.op_b == '0) exec_err = 1'b1;
        else                  exec_div = 1'b1;
      end
      default:  exec_err = 1'b1;
    endcase
  end

  assign div_start = (state == EXEC) && exec_div;

  seq_divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (instr.op_a),
    .divisor   (instr.op_b),
    .quotient  (quotient),
    .remainder (remainder),
    .div_done  (div_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      instr        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_pointer <= '0;
      res_valid    <= 1'b0;
      res_addr     <= '0;
      res_opcode   <= OP_ZERO;
      res_value    <= '0;
      res_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              addr         <= start_addr;
              read_pointer <= start_addr;
              remaining    <= count;
              state        <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        FETCH: begin
          instr <= instruction_word;
          state <= EXEC;
        end
        EXEC: begin
          res_addr   <= addr;
          res_opcode <= instr.opcode;
          if (exec_div) begin
            state <= DIVWAIT;
          end else begin
            res_value <= exec_value;
            res_err   <= exec_err;
            res_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        DIVWAIT: begin
          if (div_done) begin
            res_value <= (instr.opcode == OP_DIV) ? quotient : remainder;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            addr      <= addr + 5'd1;
            remaining <= remaining - 6'd1;
            if (remaining > 6'd1) begin
              read_pointer <= addr + 5'd1;
              state        <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Self-checking bench: directed scenarios plus randomized batches scored
// against a plain-arithmetic reference model of the instruction set.
module tb_instr_exec_sequencer;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  address_t     start_addr;
  logic [5:0]   count;
  logic         busy;
  logic         done;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         res_valid;
  logic         res_ready;
  address_t     res_addr;
  opcode_t      res_opcode;
  result_t      res_value;
  logic         res_err;

  instruction_t mem [32];
  assign instruction_word = mem[read_pointer];

  always #5 clk = ~clk;

  instr_exec_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .start_addr       (start_addr),
    .count            (count),
    .busy             (busy),
    .done             (done),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_addr         (res_addr),
    .res_opcode       (res_opcode),
    .res_value        (res_value),
    .res_err          (res_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     addr;
    int     op;
    longint value;
    bit     err;
  } exp_t;

  exp_t exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic instruction_t mk(input int op, input int a, input int b);
    instruction_t ins;
    ins.opcode = op[3:0];
    ins.op_a   = a;
    ins.op_b   = b;
    return ins;
  endfunction

  function automatic void ref_exec(input instruction_t ins, output longint v, output bit e);
    longint a = $signed(ins.op_a);
    longint b = $signed(ins.op_b);
    v = 0;
    e = 1'b0;
    case (int'(ins.opcode))
      0: v = 0;
      1: v = a;
      2: v = b;
      3: v = a + b;
      4: v = a - b;
      5: v = a * b;
      6: if (b == 0) e = 1'b1; else v = a / b;
      7: if (b == 0) e = 1'b1; else v = a % b;
      default: e = 1'b1;
    endcase
  endfunction

  function automatic instruction_t rand_instr();
    int op, a, b;
    op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
    a  = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
    b  = ($urandom_range(0, 5) == 0) ? 0
       : ($urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 40)) - 20);
    return mk(op, a, b);
  endfunction

  task automatic start_batch(input address_t sa, input int n);
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    count      = n[5:0];
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Single-instruction batch with res_ready held high; latency counted in negedges after the start edge.
  task automatic run_one(input string tag, input address_t sa, input instruction_t ins,
                         input int exp_lat, input longint exp_val, input bit exp_err);
    int k = 0;
    int dcnt = 0;
    bit seen = 1'b0;
    mem[sa]   = ins;
    res_ready = 1'b1;
    start_batch(sa, 1);
    while (k < 100 && !seen) begin
      @(negedge clk);
      k++;
      if (res_valid) seen = 1'b1;
    end
    check_eq({tag, "_seen"},   64'(seen), 64'd1);
    check_eq({tag, "_lat"},    64'(k), 64'(exp_lat));
    check_eq({tag, "_value"},  res_value, exp_val);
    check_eq({tag, "_err"},    64'(res_err), 64'(exp_err));
    check_eq({tag, "_addr"},   64'(res_addr), 64'(sa));
    check_eq({tag, "_opcode"}, 64'(res_opcode), 64'(ins.opcode));
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check_eq({tag, "_done_pulses"}, 64'(dcnt), 64'd1);
    check_eq({tag, "_busy_after"},  64'(busy), 64'd0);
  endtask

  task automatic run_batch(input address_t sa, input int n);
    longint  v;
    bit      e;
    bit      hold = 1'b0;
    bit      fin = 1'b0;
    bit      accept;
    int      dcnt = 0;
    result_t pv;
    address_t pa;
    opcode_t po;
    logic    pe;
    exp_t    x;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      int a = (int'(sa) + i) % 32;
      mem[a] = rand_instr();
      ref_exec(mem[a], v, e);
      exp_q.push_back('{addr: a, op: int'(mem[a].opcode), value: v, err: e});
    end
    start_batch(sa, n);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (hold) begin
        check_eq("hold_valid",  64'(res_valid), 64'd1);
        check_eq("hold_value",  res_value, pv);
        check_eq("hold_addr",   64'(res_addr), 64'(pa));
        check_eq("hold_opcode", 64'(res_opcode), 64'(po));
        check_eq("hold_err",    64'(res_err), 64'(pe));
      end
      if (done) dcnt++;
      if (!busy) begin
        fin = 1'b1;
      end else begin
        res_ready = ($urandom_range(0, 3) != 0);
        accept    = res_valid && res_ready;
        if (accept) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_result", 64'(exp_q.size()), 64'd1);
          end else begin
            x = exp_q.pop_front();
            check_eq("batch_addr",   64'(res_addr), 64'(x.addr));
            check_eq("batch_opcode", 64'(res_opcode), 64'(x.op));
            check_eq("batch_value",  res_value, x.value);
            check_eq("batch_err",    64'(res_err), 64'(x.err));
          end
        end
        hold = res_valid && !accept;
        pv = res_value;
        pa = res_addr;
        po = res_opcode;
        pe = res_err;
      end
    end
    check_eq("batch_finished", 64'(fin), 64'd1);
    check_eq("batch_drained",  64'(exp_q.size()), 64'd0);
    check_eq("batch_done_pulses", 64'(dcnt), 64'd1);
  endtask

  initial begin
    int k;
    int dcnt;
    int vcnt;
    bit seen;
    address_t rp_before;
    result_t snap_v;
    address_t snap_a;

    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",   64'(busy), 64'd0);
    check_eq("rst_done",   64'(done), 64'd0);
    check_eq("rst_valid",  64'(res_valid), 64'd0);
    check_eq("rst_err",    64'(res_err), 64'd0);
    check_eq("rst_rp",     64'(read_pointer), 64'd0);
    check_eq("rst_addr",   64'(res_addr), 64'd0);
    check_eq("rst_opcode", 64'(res_opcode), 64'd0);
    check_eq("rst_value",  res_value, 64'd0);
    reset = 1'b0;

    run_one("add",     5'd4,  mk(3, 5, -3),    3,  2,   1'b0);
    run_one("mult",    5'd9,  mk(5, -7, 6),    3,  -42, 1'b0);
    run_one("div",     5'd15, mk(6, -17, 5),   35, -3,  1'b0);
    run_one("mod",     5'd16, mk(7, -17, 5),   35, -2,  1'b0);
    run_one("div0",    5'd20, mk(6, 8, 0),     3,  0,   1'b1);
    run_one("mod0",    5'd19, mk(7, -8, 0),    3,  0,   1'b1);
    run_one("undef",   5'd21, mk(11, 1, 2),    3,  0,   1'b1);
    run_one("div_ovf", 5'd22, mk(6, int'(32'h8000_0000), -1), 35, 64'sd2147483648, 1'b0);

    // Backpressure: result must sit still for 10 cycles, then leave on the first ready.
    mem[12] = mk(4, 100, 250);
    res_ready = 1'b0;
    start_batch(5'd12, 1);
    k = 0; seen = 1'b0;
    while (k < 100 && !seen) begin
      @(negedge clk);
      k++;
      if (res_valid) seen = 1'b1;
    end
    check_eq("bp_seen",  64'(seen), 64'd1);
    check_eq("bp_value", res_value, -64'sd150);
    snap_v = res_value;
    snap_a = res_addr;
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_hold_valid", 64'(res_valid), 64'd1);
      check_eq("bp_hold_value", res_value, snap_v);
      check_eq("bp_hold_addr",  64'(res_addr), 64'(snap_a));
      check_eq("bp_no_done",    64'(done), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_released", 64'(res_valid), 64'd0);
    check_eq("bp_done",     64'(done), 64'd1);
    repeat (2) @(negedge clk);

    // Empty batch: done pulses once, nothing is read or produced.
    rp_before = read_pointer;
    start_batch(5'd5, 0);
    dcnt = 0; vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
      if (res_valid) vcnt++;
    end
    check_eq("empty_done_pulses", 64'(dcnt), 64'd1);
    check_eq("empty_no_result",   64'(vcnt), 64'd0);
    check_eq("empty_rp_held",     64'(read_pointer), 64'(rp_before));

    run_batch(5'd30, 4);

    // Reset while the divider is running.
    mem[7] = mk(6, -17, 5);
    res_ready = 1'b1;
    start_batch(5'd7, 1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_busy",   64'(busy), 64'd0);
    check_eq("mid_rst_done",   64'(done), 64'd0);
    check_eq("mid_rst_valid",  64'(res_valid), 64'd0);
    check_eq("mid_rst_rp",     64'(read_pointer), 64'd0);
    check_eq("mid_rst_addr",   64'(res_addr), 64'd0);
    check_eq("mid_rst_value",  res_value, 64'd0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || busy) vcnt++;
    end
    check_eq("mid_rst_quiet", 64'(vcnt), 64'd0);
    run_one("post_rst_add", 5'd3, mk(3, 1000, -1), 3, 999, 1'b0);

    for (int b = 0; b < 25; b++) begin
      run_batch(5'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
